// File: rtl/mm_stream_pkg.sv
// +-----------------------------------------------------------------------+
// | mm_stream_pkg : shared types and constants for the result-stream demux |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package mm_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LANE0 = 2'd1,
        LANE1 = 2'd2
    } state_t;

    localparam logic LANE_0 = 1'b0;
    localparam logic LANE_1 = 1'b1;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_out_reg.sv
// +-----------------------------------------------------------------------+
// | lane_out_reg : one-entry valid/data output register with load/drain    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module lane_out_reg #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    // A load in the same cycle as a drain wins, keeping the entry full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_demux2_1.sv
// +-----------------------------------------------------------------------+
// | stream_demux2_1 : splits one stream into two lanes in alternating      |
// | fixed-length bursts, framed by start/done. Rev 1.0                     |
// +-----------------------------------------------------------------------+
`default_nettype none

module stream_demux2_1
    import mm_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 4,
    parameter int PAIRS      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m0_valid,
    input  logic                  m0_ready,
    output logic [DATA_WIDTH-1:0] m0_data,
    output logic                  m1_valid,
    input  logic                  m1_ready,
    output logic [DATA_WIDTH-1:0] m1_data,
    output logic                  lane_sel,
    output logic                  busy,
    output logic                  done
);

    localparam int BCW = cnt_width(BURST_LEN);
    localparam int PCW = cnt_width(PAIRS);
    localparam logic [BCW-1:0] C_BEAT_LAST = BCW'(BURST_LEN - 1);
    localparam logic [PCW-1:0] C_PAIR_LAST = PCW'(PAIRS - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [BCW-1:0] r_beat_cnt;
    logic [BCW-1:0] w_beat_cnt_nxt;
    logic [PCW-1:0] r_pair_cnt;
    logic [PCW-1:0] w_pair_cnt_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic           w_load0;
    logic           w_load1;
    logic           w_beat_last;

    assign w_beat_last = (r_beat_cnt == C_BEAT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_pair_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_pair_cnt <= w_pair_cnt_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // s_ready depends only on state and the active lane's register, never on s_valid.
    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_pair_cnt_nxt = r_pair_cnt;
        w_done_nxt     = 1'b0;
        w_load0        = 1'b0;
        w_load1        = 1'b0;
        s_ready        = 1'b0;
        lane_sel       = LANE_0;
        busy           = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LANE0;
                end
            end

            LANE0: begin
                busy    = 1'b1;
                s_ready = !m0_valid || m0_ready;
                if (s_valid && s_ready) begin
                    w_load0 = 1'b1;
                    if (w_beat_last) begin
                        w_beat_cnt_nxt = '0;
                        w_state_nxt    = LANE1;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end

            LANE1: begin
                busy     = 1'b1;
                lane_sel = LANE_1;
                s_ready  = !m1_valid || m1_ready;
                if (s_valid && s_ready) begin
                    w_load1 = 1'b1;
                    if (w_beat_last) begin
                        w_beat_cnt_nxt = '0;
                        if (r_pair_cnt == C_PAIR_LAST) begin
                            w_pair_cnt_nxt = '0;
                            w_state_nxt    = IDLE;
                            w_done_nxt     = 1'b1;
                        end else begin
                            w_pair_cnt_nxt = r_pair_cnt + 1'b1;
                            w_state_nxt    = LANE0;
                        end
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign done = r_done;

    lane_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load0),
        .load_data (s_data),
        .ready     (m0_ready),
        .valid     (m0_valid),
        .data      (m0_data)
    );

    lane_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load1),
        .load_data (s_data),
        .ready     (m1_ready),
        .valid     (m1_valid),
        .data      (m1_data)
    );

endmodule

`default_nettype wire

// File: doc/stream_demux2_1.md
# stream_demux2_1

Output-side steering controller for the matrix-multiply datapath: accepts a single ready/valid result stream and splits it into two lanes in fixed-length alternating bursts, mirroring the alternating 2:1 input-mux sequencing on the feed side. Each lane has a one-entry output register with its own ready/valid handshake. The block frames a whole transfer of `PAIRS` lane-0/lane-1 burst pairs, started by `start` and closed by a `done` pulse.

## Interface
- `DATA_WIDTH`, 64, width of one stream beat.
- `BURST_LEN`, 4, beats routed to one lane before switching; must be ≥ 1.
- `PAIRS`, 2, lane-0/lane-1 burst pairs per transfer; must be ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a transfer; honoured only in IDLE.
- `s_valid`  in  1  upstream beat valid.
- `s_ready`  out  1  upstream beat accepted when `s_valid && s_ready`.
- `s_data`  in  DATA_WIDTH  upstream beat.
- `m0_valid` / `m1_valid`  out  1  lane output register holds a beat.
- `m0_ready` / `m1_ready`  in  1  lane consumer ready.
- `m0_data` / `m1_data`  out  DATA_WIDTH  lane output register contents.
- `lane_sel`  out  1  lane currently receiving (0 or 1); 0 in IDLE.
- `busy`  out  1  high in LANE0/LANE1.
- `done`  out  1  one-cycle pulse after the last beat of the transfer is accepted.

## Operation
- FSM states: IDLE, LANE0, LANE1.
- IDLE → LANE0 on `start`. `start` is ignored in any other state.
- In LANE*x*, `s_ready = !mX_valid || mX_ready`. The other lane's register is not written.
- Accepted beat: `mX_data <= s_data`, `mX_valid <= 1`, `beat_cnt` increments.
- When `beat_cnt == BURST_LEN-1` and a beat is accepted:
  - `beat_cnt` wraps to 0.
  - LANE0 → LANE1.
  - LANE1 → LANE0 and `pair_cnt` increments, unless `pair_cnt == PAIRS-1`. In that case the FSM goes to IDLE, `pair_cnt` clears, and `done` pulses the next cycle.
- Lane register drain: `mX_valid` clears on `mX_valid && mX_ready`, unless a new beat loads in the same cycle. Simultaneous load and drain keeps `mX_valid` = 1 with the new data.
- Output registers drain independently of FSM state, including while IDLE after `done`.
- Beats offered in IDLE are not accepted (`s_ready` = 0).
- Counter widths: `beat_cnt` is `$clog2(BURST_LEN)`, minimum 1 bit; `pair_cnt` is `$clog2(PAIRS)`, minimum 1 bit. Wrap is by explicit compare, never by natural overflow.

## Timing
- Reset values:
  - state = IDLE
  - `beat_cnt` = `pair_cnt` = 0
  - `m0_valid` = `m1_valid` = 0
  - `m0_data` = `m1_data` = 0
  - `s_ready` = 0, `lane_sel` = 0, `busy` = 0, `done` = 0
- Reset asserted mid-transfer: everything returns to the reset values immediately. Any beats held in the lane registers are discarded.
- Latency: a beat accepted at edge *n* is visible on `mX_data`/`mX_valid` after edge *n*, i.e. 1 cycle.
- Throughput: 1 beat/cycle when the active lane's consumer holds ready high, including across lane switches with no bubble.
- `s_ready` is combinational from state and `mX_valid`/`mX_ready`. No combinational path exists from `s_valid` to `s_ready`.
- `done` is registered and high for exactly 1 cycle. A `start` in the same cycle as `done` (FSM already IDLE) begins a new transfer.

## Structure
- Shared package (e.g. `mm_stream_pkg`):
  - FSM state enum `{IDLE, LANE0, LANE1}`.
  - Lane index constants `LANE_0 = 1'b0`, `LANE_1 = 1'b1`.
- One natural sub-module: `lane_out_reg`, the one-entry valid/data register with load/drain. It is instantiated twice.
- FSM and counters live in the top level.

## Test plan
- Reset then `start`, BURST_LEN=4, PAIRS=2, beats 1..16, both readies high:
  - Lane 0 gets 1–4 and 9–12; lane 1 gets 5–8 and 13–16.
  - `done` pulses 1 cycle after beat 16 is accepted.
  - 16 consecutive accept cycles.
- Hold `m0_ready` = 0 during the first burst:
  - Lane 0 holds beat 1, `s_ready` drops after 1 accept, lane 1 stays empty.
  - Releasing `m0_ready` resumes flow with no loss or duplication.
- `s_valid` high in IDLE with no `start`:
  - `s_ready` stays 0, no lane loads, `busy` = 0.
- `start` pulsed mid-transfer (after beat 6):
  - Ignored; `lane_sel`, counters and routing unchanged.
  - `done` appears only after beat 16.
- Assert `rst_n` = 0 asynchronously after beat 7 with `m1_valid` = 1:
  - All outputs drop to reset values before the next edge.
  - A new `start` routes its first beat to lane 0.
- BURST_LEN=1, PAIRS=1: beats A, B go to lane 0 then lane 1, `done` follows B, and both counters remain at 0 throughout.
